trace_line_arbiter: RTL and testbench

Two-requester, line-granular arbiter that shares one `cpu_checker` between two trace-character producers. It grants the checker input to one producer for a whole trace record, from `^` through `#`, so records from the two sources never interleave. It reads back `format_type` after each record and keeps per-outcome statistics. It sits directly in front of the checker's `char` input.

---
 rtl/trace_line_arbiter.sv | 195 +++++++++++++++++++
 tb/tb_trace_line_arbiter.sv | 353 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/trace_line_arbiter.sv
// trace_line_arbiter: grants a shared trace checker to one of two character
// producers for a whole record ('^' .. '#'), so records never interleave.
// Optional statistics (ok/bad/abort counters, last format) are built only when
// the macro TRACE_ARB_STATS_EN is defined; otherwise those outputs read 0.
module trace_line_arbiter #(
    parameter int MAX_LEN = 64
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req0_valid,
    input  logic [7:0]  req0_char,
    output logic        req0_ready,
    input  logic        req1_valid,
    input  logic [7:0]  req1_char,
    output logic        req1_ready,
    output logic [7:0]  chk_char,
    input  logic [1:0]  chk_fmt,
    output logic        grant_id,
    output logic        busy,
    output logic [15:0] ok_cnt,
    output logic [15:0] bad_cnt,
    output logic [15:0] abort_cnt,
    output logic [1:0]  last_fmt
);

    localparam int              LEN_W     = $clog2(MAX_LEN + 1);
    localparam logic [LEN_W-1:0] MAX_LEN_V = LEN_W'(MAX_LEN);
    localparam logic [7:0]      CH_START  = 8'h5E;  // '^'
    localparam logic [7:0]      CH_END    = 8'h23;  // '#'

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOCK  = 2'd1,
        ST_FLUSH = 2'd2
    } state_t;

    state_t             state_q;
    logic               rr_q;
    logic               owner_q;
    logic [LEN_W-1:0]   len_q;
    logic [LEN_W-1:0]   len_d;

    logic               cand0;
    logic               cand1;
    logic               own_valid;
    logic [7:0]         own_char;
    logic               do_grant;
    logic               grant_win;
    logic               line_end;
    logic               line_abort;

    // A requester is a grant candidate only while offering a record start.
    assign cand0     = req0_valid && (req0_char == CH_START);
    assign cand1     = req1_valid && (req1_char == CH_START);
    assign own_valid = owner_q ? req1_valid : req0_valid;
    assign own_char  = owner_q ? req1_char  : req0_char;
    assign len_d     = len_q + 1'b1;

    assign grant_id  = owner_q;
    assign busy      = (state_q != ST_IDLE);

    // Zero-latency handshake and checker feed; also decides grant/end/abort.
    // Everything is forced quiet while reset is high so nothing leaks out.
    always_comb begin
        req0_ready = 1'b0;
        req1_ready = 1'b0;
        chk_char   = 8'h00;
        do_grant   = 1'b0;
        grant_win  = 1'b0;
        line_end   = 1'b0;
        line_abort = 1'b0;
        if (!reset) begin
            case (state_q)
                ST_IDLE: begin
                    // Tie goes to the round-robin favourite, else the sole candidate.
                    grant_win = (cand0 && cand1) ? rr_q : cand1;
                    if (cand0 || cand1) begin
                        do_grant = 1'b1;
                        chk_char = CH_START;
                    end
                    // Non-candidates are drained (garbage dropped); a losing
                    // candidate is held so its '^' survives to the next grant.
                    req0_ready = req0_valid && (!cand0 || !grant_win);
                    req1_ready = req1_valid && (!cand1 ||  grant_win);
                end
                ST_LOCK: begin
                    if (own_valid) begin
                        chk_char = own_char;
                        if (owner_q) begin
                            req1_ready = 1'b1;
                        end else begin
                            req0_ready = 1'b1;
                        end
                        if (own_char == CH_END) begin
                            line_end = 1'b1;
                        end else if (len_d >= MAX_LEN_V) begin
                            line_abort = 1'b1;
                        end
                    end else begin
                        // Owner stalled mid-record: drop the line, checker sees 00.
                        line_abort = 1'b1;
                    end
                end
                default: begin
                    // FLUSH: gap cycle while the checker publishes its verdict.
                end
            endcase
        end
    end

    // Arbiter FSM: ownership, line length and round-robin pointer.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            rr_q    <= 1'b0;
            owner_q <= 1'b0;
            len_q   <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (do_grant) begin
                        owner_q <= grant_win;
                        len_q   <= LEN_W'(1);
                        state_q <= ST_LOCK;
                    end
                end
                ST_LOCK: begin
                    if (own_valid) begin
                        len_q <= len_d;
                    end
                    if (line_end) begin
                        state_q <= ST_FLUSH;
                    end else if (line_abort) begin
                        rr_q    <= ~owner_q;
                        state_q <= ST_IDLE;
                    end
                end
                ST_FLUSH: begin
                    rr_q    <= ~owner_q;
                    state_q <= ST_IDLE;
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

`ifdef TRACE_ARB_STATS_EN
    logic        flush_now;
    logic [2:0]  cnt_evt;
    logic [15:0] cnt_q [3];
    logic [1:0]  last_fmt_q;

    assign flush_now  = (state_q == ST_FLUSH);
    assign cnt_evt[0] = flush_now && (chk_fmt != 2'b00);
    assign cnt_evt[1] = flush_now && (chk_fmt == 2'b00);
    assign cnt_evt[2] = line_abort;

    // One saturating counter per outcome: 0 = ok, 1 = bad, 2 = abort.
    generate
        for (genvar gi = 0; gi < 3; gi++) begin : g_cnt
            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    cnt_q[gi] <= '0;
                end else if (cnt_evt[gi] && (cnt_q[gi] != 16'hFFFF)) begin
                    cnt_q[gi] <= cnt_q[gi] + 16'd1;
                end
            end
        end
    endgenerate

    // Capture the checker verdict shown during the flush cycle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            last_fmt_q <= 2'b00;
        end else if (flush_now) begin
            last_fmt_q <= chk_fmt;
        end
    end

    assign ok_cnt    = cnt_q[0];
    assign bad_cnt   = cnt_q[1];
    assign abort_cnt = cnt_q[2];
    assign last_fmt  = last_fmt_q;
`else
    logic unused_fmt;
    assign unused_fmt = ^chk_fmt;
    assign ok_cnt     = 16'h0000;
    assign bad_cnt    = 16'h0000;
    assign abort_cnt  = 16'h0000;
    assign last_fmt   = 2'b00;
`endif

endmodule

// File: tb/tb_trace_line_arbiter.sv
// Directed bench for trace_line_arbiter; counter expectations follow whether
// TRACE_ARB_STATS_EN is defined for this build.
module tb_trace_line_arbiter;

`ifdef TRACE_ARB_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic        r0v, r1v;
    logic [7:0]  r0c, r1c;
    logic [1:0]  fmt;
    logic        req0_ready, req1_ready, grant_id, busy;
    logic [7:0]  chk_char;
    logic [15:0] ok_cnt, bad_cnt, abort_cnt;
    logic [1:0]  last_fmt;

    // Second instance with a short MAX_LEN for the length-limit case.
    logic        s0v, s1v;
    logic [7:0]  s0c, s1c;
    logic [1:0]  sfmt;
    logic        s_r0, s_r1, s_gid, s_busy;
    logic [7:0]  s_chk;
    logic [15:0] s_ok, s_bad, s_abort;
    logic [1:0]  s_last;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    trace_line_arbiter dut (
        .clk(clk), .reset(reset),
        .req0_valid(r0v), .req0_char(r0c), .req0_ready(req0_ready),
        .req1_valid(r1v), .req1_char(r1c), .req1_ready(req1_ready),
        .chk_char(chk_char), .chk_fmt(fmt),
        .grant_id(grant_id), .busy(busy),
        .ok_cnt(ok_cnt), .bad_cnt(bad_cnt), .abort_cnt(abort_cnt), .last_fmt(last_fmt)
    );

    trace_line_arbiter #(.MAX_LEN(16)) dut16 (
        .clk(clk), .reset(reset),
        .req0_valid(s0v), .req0_char(s0c), .req0_ready(s_r0),
        .req1_valid(s1v), .req1_char(s1c), .req1_ready(s_r1),
        .chk_char(s_chk), .chk_fmt(sfmt),
        .grant_id(s_gid), .busy(s_busy),
        .ok_cnt(s_ok), .bad_cnt(s_bad), .abort_cnt(s_abort), .last_fmt(s_last)
    );

    function automatic logic [15:0] stat(input int n);
        return STATS ? 16'(n) : 16'd0;
    endfunction

    function automatic logic [1:0] fexp(input logic [1:0] f);
        return STATS ? f : 2'b00;
    endfunction

    task automatic do_reset;
        @(negedge clk);
        reset = 1'b1;
        r0v = 0; r1v = 0; r0c = 0; r1c = 0; fmt = 0;
        s0v = 0; s1v = 0; s0c = 0; s1c = 0; sfmt = 0;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_reset;
        @(negedge clk);
        reset = 1'b1;
        r0v = 1; r0c = 8'h5E; r1v = 1; r1c = 8'h5E; fmt = 2'b01;
        s0v = 0; s1v = 0; s0c = 0; s1c = 0; sfmt = 0;
        #1;
        checks++;
        if (chk_char !== 8'h00 || req0_ready !== 1'b0 || req1_ready !== 1'b0) begin
            errors++;
            $display("FAIL reset_comb: chk=%h r0=%b r1=%b expected chk=00 r0=0 r1=0", chk_char, req0_ready, req1_ready);
        end
        checks++;
        if (busy !== 1'b0 || grant_id !== 1'b0) begin
            errors++;
            $display("FAIL reset_state: busy=%b gid=%b expected 0 0", busy, grant_id);
        end
        checks++;
        if (ok_cnt !== 16'd0 || bad_cnt !== 16'd0 || abort_cnt !== 16'd0 || last_fmt !== 2'b00) begin
            errors++;
            $display("FAIL reset_stats: ok=%0d bad=%0d abort=%0d last=%b expected all 0", ok_cnt, bad_cnt, abort_cnt, last_fmt);
        end
        @(negedge clk);
        r0v = 0; r1v = 0; fmt = 0;
        reset = 1'b0;
        $display("txn reset: done");
    endtask

    task automatic test_single_stream;
        string s;
        s = "^12@00003000: $ 1 <= 0000000a#";
        do_reset();
        for (int i = 0; i < s.len(); i++) begin
            @(negedge clk); r0v = 1; r0c = s[i]; #1;
            checks++;
            if (req0_ready !== 1'b1 || chk_char !== s[i]) begin
                errors++;
                $display("FAIL single_char[%0d]: ready=%b chk=%h expected ready=1 chk=%h", i, req0_ready, chk_char, s[i]);
            end
        end
        @(negedge clk); r0v = 0; fmt = 2'b01; #1;
        checks++;
        if (busy !== 1'b1 || chk_char !== 8'h00) begin
            errors++;
            $display("FAIL single_flush: busy=%b chk=%h expected busy=1 chk=00", busy, chk_char);
        end
        @(negedge clk); fmt = 2'b00; #1;
        checks++;
        if (ok_cnt !== stat(1) || last_fmt !== fexp(2'b01) || busy !== 1'b0 || grant_id !== 1'b0) begin
            errors++;
            $display("FAIL single_stats: ok=%0d last=%b busy=%b gid=%b expected ok=%0d last=%b busy=0 gid=0",
                     ok_cnt, last_fmt, busy, grant_id, stat(1), fexp(2'b01));
        end
        $display("txn single_stream: %0d chars from requester 0", s.len());
    endtask

    task automatic test_tie;
        string a, b;
        a = "AB#";
        b = "C#";
        do_reset();
        @(negedge clk); r0v = 1; r0c = 8'h5E; r1v = 1; r1c = 8'h5E; #1;
        checks++;
        if (req0_ready !== 1'b1 || req1_ready !== 1'b0 || chk_char !== 8'h5E) begin
            errors++;
            $display("FAIL tie_grant: r0=%b r1=%b chk=%h expected r0=1 r1=0 chk=5e", req0_ready, req1_ready, chk_char);
        end
        for (int i = 0; i < a.len(); i++) begin
            @(negedge clk); r0c = a[i]; #1;
            checks++;
            if (req0_ready !== 1'b1 || req1_ready !== 1'b0 || chk_char !== a[i]) begin
                errors++;
                $display("FAIL tie_lock0[%0d]: r0=%b r1=%b chk=%h expected r0=1 r1=0 chk=%h", i, req0_ready, req1_ready, chk_char, a[i]);
            end
        end
        @(negedge clk); r0v = 0; fmt = 2'b01; #1;
        checks++;
        if (req1_ready !== 1'b0 || chk_char !== 8'h00) begin
            errors++;
            $display("FAIL tie_flush: r1=%b chk=%h expected r1=0 chk=00", req1_ready, chk_char);
        end
        @(negedge clk); fmt = 2'b00; #1;
        checks++;
        if (req1_ready !== 1'b1 || chk_char !== 8'h5E || busy !== 1'b0) begin
            errors++;
            $display("FAIL tie_second_grant: r1=%b chk=%h busy=%b expected r1=1 chk=5e busy=0", req1_ready, chk_char, busy);
        end
        for (int i = 0; i < b.len(); i++) begin
            @(negedge clk); r1c = b[i]; #1;
            checks++;
            if (req1_ready !== 1'b1 || grant_id !== 1'b1 || chk_char !== b[i]) begin
                errors++;
                $display("FAIL tie_lock1[%0d]: r1=%b gid=%b chk=%h expected r1=1 gid=1 chk=%h", i, req1_ready, grant_id, chk_char, b[i]);
            end
        end
        @(negedge clk); r1v = 0; fmt = 2'b10; #1;
        @(negedge clk); fmt = 2'b00; #1;
        checks++;
        if (ok_cnt !== stat(2) || last_fmt !== fexp(2'b10) || grant_id !== 1'b1) begin
            errors++;
            $display("FAIL tie_stats: ok=%0d last=%b gid=%b expected ok=%0d last=%b gid=1", ok_cnt, last_fmt, grant_id, stat(2), fexp(2'b10));
        end
        $display("txn tie: requester 0 then requester 1");
    endtask

    task automatic test_garbage;
        string s;
        logic [7:0] e;
        s = "ab^5@00003004: *00000010 <= 00000002#";
        do_reset();
        for (int i = 0; i < s.len(); i++) begin
            @(negedge clk); r1v = 1; r1c = s[i]; #1;
            e = (i < 2) ? 8'h00 : s[i];
            checks++;
            if (req1_ready !== 1'b1 || chk_char !== e) begin
                errors++;
                $display("FAIL garbage_char[%0d]: ready=%b chk=%h expected ready=1 chk=%h", i, req1_ready, chk_char, e);
            end
        end
        @(negedge clk); r1v = 0; fmt = 2'b10; #1;
        @(negedge clk); fmt = 2'b00; #1;
        checks++;
        if (ok_cnt !== stat(1) || last_fmt !== fexp(2'b10) || grant_id !== 1'b1) begin
            errors++;
            $display("FAIL garbage_stats: ok=%0d last=%b gid=%b expected ok=%0d last=%b gid=1", ok_cnt, last_fmt, grant_id, stat(1), fexp(2'b10));
        end
        $display("txn garbage: 2 chars dropped, record from requester 1");
    endtask

    task automatic test_abort;
        string s;
        s = "^1@";
        do_reset();
        for (int i = 0; i < s.len(); i++) begin
            @(negedge clk); r0v = 1; r0c = s[i];
            if (i > 0) begin
                r1v = 1; r1c = 8'h5E;
            end
            #1;
            checks++;
            if (req0_ready !== 1'b1 || chk_char !== s[i] || (i > 0 && req1_ready !== 1'b0)) begin
                errors++;
                $display("FAIL abort_lock[%0d]: r0=%b r1=%b chk=%h expected r0=1 r1=0 chk=%h", i, req0_ready, req1_ready, chk_char, s[i]);
            end
        end
        @(negedge clk); r0v = 0; #1;
        checks++;
        if (chk_char !== 8'h00 || req1_ready !== 1'b0 || busy !== 1'b1) begin
            errors++;
            $display("FAIL abort_cycle: chk=%h r1=%b busy=%b expected chk=00 r1=0 busy=1", chk_char, req1_ready, busy);
        end
        // Both offer '^' now; the pointer must favour requester 1 after the abort.
        @(negedge clk); r0v = 1; r0c = 8'h5E; #1;
        checks++;
        if (busy !== 1'b0 || abort_cnt !== stat(1) || req1_ready !== 1'b1 || req0_ready !== 1'b0 || chk_char !== 8'h5E) begin
            errors++;
            $display("FAIL abort_regrant: busy=%b abort=%0d r0=%b r1=%b chk=%h expected busy=0 abort=%0d r0=0 r1=1 chk=5e",
                     busy, abort_cnt, req0_ready, req1_ready, chk_char, stat(1));
        end
        @(negedge clk); r1c = 8'h23; #1;
        checks++;
        if (grant_id !== 1'b1 || req1_ready !== 1'b1 || req0_ready !== 1'b0 || chk_char !== 8'h23) begin
            errors++;
            $display("FAIL abort_line1: gid=%b r0=%b r1=%b chk=%h expected gid=1 r0=0 r1=1 chk=23", grant_id, req0_ready, req1_ready, chk_char);
        end
        @(negedge clk); r1v = 0; fmt = 2'b00; #1;
        @(negedge clk); #1;
        checks++;
        if (req0_ready !== 1'b1 || chk_char !== 8'h5E || bad_cnt !== stat(1) || abort_cnt !== stat(1)) begin
            errors++;
            $display("FAIL abort_after: r0=%b chk=%h bad=%0d abort=%0d expected r0=1 chk=5e bad=%0d abort=%0d",
                     req0_ready, chk_char, bad_cnt, abort_cnt, stat(1), stat(1));
        end
        @(negedge clk); r0c = 8'h23; #1;
        @(negedge clk); r0v = 0; #1;
        @(negedge clk); #1;
        $display("txn abort: requester 0 dropped, requester 1 granted");
    endtask

    task automatic test_malformed;
        string s;
        s = "^1@0000300g:#";
        do_reset();
        for (int i = 0; i < s.len(); i++) begin
            @(negedge clk); r0v = 1; r0c = s[i]; #1;
            checks++;
            if (req0_ready !== 1'b1 || chk_char !== s[i]) begin
                errors++;
                $display("FAIL malformed_char[%0d]: ready=%b chk=%h expected ready=1 chk=%h", i, req0_ready, chk_char, s[i]);
            end
        end
        @(negedge clk); r0v = 0; fmt = 2'b00; #1;
        @(negedge clk); #1;
        checks++;
        if (bad_cnt !== stat(1) || ok_cnt !== 16'd0 || last_fmt !== 2'b00 || busy !== 1'b0) begin
            errors++;
            $display("FAIL malformed_stats: bad=%0d ok=%0d last=%b busy=%b expected bad=%0d ok=0 last=00 busy=0", bad_cnt, ok_cnt, last_fmt, busy, stat(1));
        end
        $display("txn malformed: record judged bad");
    endtask

    task automatic test_max_len;
        string s;
        s = "^0123456789ABCDEFGHI";
        do_reset();
        for (int i = 0; i < s.len(); i++) begin
            @(negedge clk); s0v = 1; s0c = s[i]; #1;
            checks++;
            if (i < 16) begin
                if (s_r0 !== 1'b1 || s_chk !== s[i] || s_busy !== (i > 0)) begin
                    errors++;
                    $display("FAIL maxlen_char[%0d]: ready=%b chk=%h busy=%b expected ready=1 chk=%h busy=%b", i, s_r0, s_chk, s_busy, s[i], (i > 0));
                end
            end else begin
                if (s_r0 !== 1'b1 || s_chk !== 8'h00 || s_busy !== 1'b0) begin
                    errors++;
                    $display("FAIL maxlen_tail[%0d]: ready=%b chk=%h busy=%b expected ready=1 chk=00 busy=0", i, s_r0, s_chk, s_busy);
                end
            end
        end
        @(negedge clk); s0v = 0; #1;
        checks++;
        if (s_abort !== stat(1) || s_ok !== 16'd0 || s_bad !== 16'd0) begin
            errors++;
            $display("FAIL maxlen_stats: abort=%0d ok=%0d bad=%0d expected abort=%0d ok=0 bad=0", s_abort, s_ok, s_bad, stat(1));
        end
        $display("txn max_len: 20-char line cut after 16");
    endtask

    task automatic test_reset_mid_lock;
        string s;
        s = "^X#";
        do_reset();
        for (int i = 0; i < s.len(); i++) begin
            @(negedge clk); r1v = 1; r1c = s[i]; #1;
        end
        @(negedge clk); r1v = 0; fmt = 2'b01; #1;
        @(negedge clk); fmt = 2'b00; r1v = 1; r1c = 8'h5E; #1;
        @(negedge clk); r1c = 8'h31; #1;
        checks++;
        if (busy !== 1'b1 || grant_id !== 1'b1 || ok_cnt !== stat(1) || last_fmt !== fexp(2'b01)) begin
            errors++;
            $display("FAIL midlock_pre: busy=%b gid=%b ok=%0d last=%b expected busy=1 gid=1 ok=%0d last=%b",
                     busy, grant_id, ok_cnt, last_fmt, stat(1), fexp(2'b01));
        end
        #2 reset = 1'b1;
        #1;
        checks++;
        if (chk_char !== 8'h00 || req1_ready !== 1'b0 || busy !== 1'b0 || grant_id !== 1'b0) begin
            errors++;
            $display("FAIL midlock_outputs: chk=%h r1=%b busy=%b gid=%b expected chk=00 r1=0 busy=0 gid=0", chk_char, req1_ready, busy, grant_id);
        end
        checks++;
        if (ok_cnt !== 16'd0 || abort_cnt !== 16'd0 || last_fmt !== 2'b00) begin
            errors++;
            $display("FAIL midlock_stats: ok=%0d abort=%0d last=%b expected 0 0 00", ok_cnt, abort_cnt, last_fmt);
        end
        @(negedge clk); r1v = 0; reset = 1'b0;
        @(negedge clk); #1;
        checks++;
        if (abort_cnt !== 16'd0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL midlock_after: abort=%0d busy=%b expected abort=0 busy=0", abort_cnt, busy);
        end
        $display("txn reset_mid_lock: line dropped silently");
    endtask

    initial begin
        reset = 1'b1;
        r0v = 0; r1v = 0; r0c = 0; r1c = 0; fmt = 0;
        s0v = 0; s1v = 0; s0c = 0; s1c = 0; sfmt = 0;
        test_reset();
        test_single_stream();
        test_tie();
        test_garbage();
        test_abort();
        test_malformed();
        test_max_len();
        test_reset_mid_lock();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
